mapper_mem_sequencer: RTL and testbench

- Memory-side responder for the cartridge mapper blocks: services translated PRG (CPU) and CHR (PPU) accesses, i.e. mapper address plus allow, against one shared single-port external memory.
- Latches one request per side, arbitrates between sides and runs a req/ack handshake with the memory.
- Returns read data with a done pulse, and generates the response itself for disallowed accesses and for memory timeouts.

---
 rtl/mapper_pkg.sv | 30 +++
 rtl/mapper_req_latch.sv | 36 +++
 rtl/mapper_mem_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mapper_mem_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared types for the mapper memory sequencer.
// FSM states, side select, request bundle and open-bus reset value.
package mapper_pkg;

  localparam int MAP_ADDR_W = 22;
  localparam logic [7:0] OPEN_BUS_RESET = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_RESP
  } state_t;

  typedef enum logic {
    SIDE_PRG,
    SIDE_CHR
  } side_t;

  typedef struct packed {
    logic [MAP_ADDR_W-1:0] addr;
    logic                  we;
    logic [7:0]            wdata;
    logic                  allow;
  } req_t;

  function automatic side_t other_side(side_t s);
    return (s == SIDE_PRG) ? SIDE_CHR : SIDE_PRG;
  endfunction

endpackage

// File: rtl/mapper_req_latch.sv
// One-deep request capture for one side of the sequencer.
// Exposes a bypass view so an idle arbiter can act on a fresh strobe.
module mapper_req_latch
  import mapper_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  req_t d,
  input  logic clr,
  output logic avail,
  output req_t view,
  output logic drop
);

  logic pend;
  req_t q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
      q    <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (req && !pend) begin
      pend <= 1'b1;
      q    <= d;
    end
  end

  // A strobe landing on a full latch (incl. its clear cycle) is lost.
  assign drop  = req && pend;
  assign avail = pend || req;
  assign view  = pend ? q : d;

endmodule

// File: rtl/mapper_mem_sequencer.sv
// Arbitrates PRG/CHR mapper accesses onto one shared memory port.
// Answers disallowed accesses and memory timeouts locally.
module mapper_mem_sequencer
  import mapper_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prg_req,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic              prg_we,
  input  logic [7:0]        prg_wdata,
  input  logic              prg_allow,
  output logic [7:0]        prg_rdata,
  output logic              prg_done,
  input  logic              chr_req,
  input  logic [ADDR_W-1:0] chr_addr,
  input  logic              chr_we,
  input  logic [7:0]        chr_wdata,
  input  logic              chr_allow,
  output logic [7:0]        chr_rdata,
  output logic              chr_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  req_t prg_d, chr_d;
  req_t prg_view, chr_view;
  req_t pick;
  logic prg_avail, chr_avail;
  logic prg_drop, chr_drop;
  logic prg_clr, chr_clr;

  state_t           state;
  side_t            sel;
  side_t            ptr;
  logic             cur_we;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       prg_ob, chr_ob;

  logic       pick_chr;
  logic       resp_done;
  logic       hit_to;
  logic       fin;
  logic [7:0] fin_data;

  assign prg_d = '{addr: MAP_ADDR_W'(prg_addr), we: prg_we,
                   wdata: prg_wdata, allow: prg_allow};
  assign chr_d = '{addr: MAP_ADDR_W'(chr_addr), we: chr_we,
                   wdata: chr_wdata, allow: chr_allow};

  mapper_req_latch u_prg (
    .clk(clk), .reset_n(reset_n), .req(prg_req), .d(prg_d),
    .clr(prg_clr), .avail(prg_avail), .view(prg_view),
    .drop(prg_drop)
  );

  mapper_req_latch u_chr (
    .clk(clk), .reset_n(reset_n), .req(chr_req), .d(chr_d),
    .clr(chr_clr), .avail(chr_avail), .view(chr_view),
    .drop(chr_drop)
  );

  assign pick_chr  = chr_avail && (!prg_avail || ptr == SIDE_CHR);
  assign pick      = pick_chr ? chr_view : prg_view;
  assign resp_done = (sel == SIDE_PRG) ? prg_done : chr_done;
  assign hit_to    = (cnt == CNT_W'(TIMEOUT - 1));

  assign prg_clr = (state == ST_RESP) && resp_done && (sel == SIDE_PRG);
  assign chr_clr = (state == ST_RESP) && resp_done && (sel == SIDE_CHR);

  // fin marks the edge that raises the served side's done.
  always_comb begin
    fin      = 1'b0;
    fin_data = OPEN_BUS_RESET;
    unique case (state)
      ST_MEM: begin
        fin      = mem_ack || hit_to;
        fin_data = mem_ack ? mem_rdata : OPEN_BUS_RESET;
      end
      ST_RESP: begin
        fin      = !resp_done;
        fin_data = (sel == SIDE_PRG) ? prg_ob : chr_ob;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sel         <= SIDE_PRG;
      ptr         <= SIDE_CHR;
      cur_we      <= 1'b0;
      cnt         <= '0;
      prg_ob      <= OPEN_BUS_RESET;
      chr_ob      <= OPEN_BUS_RESET;
      prg_rdata   <= OPEN_BUS_RESET;
      chr_rdata   <= OPEN_BUS_RESET;
      prg_done    <= 1'b0;
      chr_done    <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      prg_done <= 1'b0;
      chr_done <= 1'b0;
      if (prg_drop || chr_drop) overflow <= 1'b1;
      if (fin) begin
        if (sel == SIDE_PRG) begin
          prg_done <= 1'b1;
          if (!cur_we) begin
            prg_rdata <= fin_data;
            prg_ob    <= fin_data;
          end
        end else begin
          chr_done <= 1'b1;
          if (!cur_we) begin
            chr_rdata <= fin_data;
            chr_ob    <= fin_data;
          end
        end
      end
      unique case (state)
        ST_IDLE: begin
          if (prg_avail || chr_avail) begin
            sel    <= pick_chr ? SIDE_CHR : SIDE_PRG;
            cur_we <= pick.we;
            cnt    <= '0;
            if (pick.allow) begin
              mem_req   <= 1'b1;
              mem_addr  <= ADDR_W'(pick.addr);
              mem_we    <= pick.we;
              mem_wdata <= pick.wdata;
              state     <= ST_MEM;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack || hit_to) begin
            mem_req <= 1'b0;
            if (!mem_ack) timeout_err <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_done) begin
            ptr   <= other_side(sel);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_mem_sequencer.sv
// Directed bench for mapper_mem_sequencer.
// Scenario tasks with inline checks against hand-derived values.
module tb_mapper_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        prg_req = 1'b0;
  logic [21:0] prg_addr = '0;
  logic        prg_we = 1'b0;
  logic [7:0]  prg_wdata = '0;
  logic        prg_allow = 1'b0;
  logic [7:0]  prg_rdata;
  logic        prg_done;
  logic        chr_req = 1'b0;
  logic [21:0] chr_addr = '0;
  logic        chr_we = 1'b0;
  logic [7:0]  chr_wdata = '0;
  logic        chr_allow = 1'b0;
  logic [7:0]  chr_rdata;
  logic        chr_done;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        overflow;
  logic        timeout_err;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int n_mem = 0;
  int n_pdone = 0;
  int n_cdone = 0;
  int mem_lat = 2;
  int wcnt = 0;
  logic [7:0] mem_data = '0;
  bit mute = 1'b0;
  bit xor_mode = 1'b0;

  mapper_mem_sequencer #(.ADDR_W(22), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .prg_req(prg_req), .prg_addr(prg_addr), .prg_we(prg_we),
    .prg_wdata(prg_wdata), .prg_allow(prg_allow),
    .prg_rdata(prg_rdata), .prg_done(prg_done),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_we(chr_we),
    .chr_wdata(chr_wdata), .chr_allow(chr_allow),
    .chr_rdata(chr_rdata), .chr_done(chr_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  // Memory model: acks on the mem_lat-th cycle mem_req is seen high.
  initial forever begin
    @(posedge clk);
    #2;
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_req) begin
      if (wcnt == 0) n_mem++;
      wcnt++;
      if (!mute && wcnt == mem_lat) begin
        mem_ack = 1'b1;
        mem_rdata = xor_mode ? (mem_addr[7:0] ^ 8'hA5) : mem_data;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (prg_done) n_pdone++;
    if (chr_done) n_cdone++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prg_issue(input logic [21:0] a, input logic we,
                           input logic [7:0] wd, input logic al);
    prg_req = 1'b1; prg_addr = a; prg_we = we;
    prg_wdata = wd; prg_allow = al;
  endtask

  task automatic chr_issue(input logic [21:0] a, input logic we,
                           input logic [7:0] wd, input logic al);
    chr_req = 1'b1; chr_addr = a; chr_we = we;
    chr_wdata = wd; chr_allow = al;
  endtask

  task automatic wait_done(input bit chr, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 200 && !seen; i++) begin
      tick();
      if (chr ? chr_done : prg_done) begin
        cyc = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    prg_req = 1'b0;
    chr_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    chk_cnt++;
    if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b want 0", mem_req);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'hFF) $display("FAIL rst_prg_rdata got %h want ff", prg_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (chr_rdata !== 8'hFF) $display("FAIL rst_chr_rdata got %h want ff", chr_rdata);
    else pass_cnt++;
    chk_cnt++;
    if ({prg_done, chr_done, overflow, timeout_err} !== 4'b0)
      $display("FAIL rst_flags got %b want 0000",
               {prg_done, chr_done, overflow, timeout_err});
    else pass_cnt++;
    chk_cnt++;
    if (mem_addr !== 22'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr);
    else pass_cnt++;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk_cnt++;
    if (mem_req !== 1'b0) $display("FAIL idle_mem_req got %b want 0", mem_req);
    else pass_cnt++;
  endtask

  task automatic test_prg_read();
    int c, m0, d0;
    mem_lat = 4; mute = 1'b0; xor_mode = 1'b0; mem_data = 8'h5A;
    m0 = n_mem; d0 = n_pdone;
    prg_issue(22'h004123, 1'b0, 8'h00, 1'b1);
    tick();
    prg_req = 1'b0;
    chk_cnt++;
    if (mem_req !== 1'b1) $display("FAIL rd_mem_req got %b want 1", mem_req);
    else pass_cnt++;
    chk_cnt++;
    if (mem_addr !== 22'h004123) $display("FAIL rd_mem_addr got %h want 004123", mem_addr);
    else pass_cnt++;
    chk_cnt++;
    if (mem_we !== 1'b0) $display("FAIL rd_mem_we got %b want 0", mem_we);
    else pass_cnt++;
    wait_done(1'b0, c);
    chk_cnt++;
    if (c !== 4) $display("FAIL rd_latency got %0d want 4", c);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'h5A) $display("FAIL rd_data got %h want 5a", prg_rdata);
    else pass_cnt++;
    tick();
    tick();
    chk_cnt++;
    if (n_pdone - d0 !== 1) $display("FAIL rd_done_cnt got %0d want 1", n_pdone - d0);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'h5A) $display("FAIL rd_hold got %h want 5a", prg_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (n_mem - m0 !== 1) $display("FAIL rd_mem_cnt got %0d want 1", n_mem - m0);
    else pass_cnt++;
  endtask

  task automatic test_both();
    int c, m0, p0, c0;
    do_reset();
    mem_lat = 2; xor_mode = 1'b1;
    m0 = n_mem; p0 = n_pdone; c0 = n_cdone;
    prg_issue(22'h001000, 1'b0, 8'h00, 1'b1);
    chr_issue(22'h000321, 1'b0, 8'h00, 1'b1);
    tick();
    prg_req = 1'b0;
    chr_req = 1'b0;
    chk_cnt++;
    if (mem_addr !== 22'h000321) $display("FAIL both_first_addr got %h want 000321", mem_addr);
    else pass_cnt++;
    wait_done(1'b1, c);
    chk_cnt++;
    if (c !== 2) $display("FAIL both_chr_lat got %0d want 2", c);
    else pass_cnt++;
    chk_cnt++;
    if (chr_rdata !== 8'h84) $display("FAIL both_chr_data got %h want 84", chr_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (n_pdone - p0 !== 0) $display("FAIL both_order got %0d prg done want 0", n_pdone - p0);
    else pass_cnt++;
    wait_done(1'b0, c);
    chk_cnt++;
    if (c !== 4) $display("FAIL both_prg_lat got %0d want 4", c);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'hA5) $display("FAIL both_prg_data got %h want a5", prg_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (mem_addr !== 22'h001000) $display("FAIL both_second_addr got %h want 001000", mem_addr);
    else pass_cnt++;
    tick(); tick(); tick();
    chk_cnt++;
    if (n_mem - m0 !== 2) $display("FAIL both_mem_cnt got %0d want 2", n_mem - m0);
    else pass_cnt++;
    chk_cnt++;
    if ((n_pdone - p0 !== 1) || (n_cdone - c0 !== 1))
      $display("FAIL both_done_cnt got %0d/%0d want 1/1", n_pdone - p0, n_cdone - c0);
    else pass_cnt++;
    xor_mode = 1'b0;
  endtask

  task automatic test_disallowed();
    int c, m0;
    mem_lat = 2; mem_data = 8'h3C;
    prg_issue(22'h000040, 1'b0, 8'h00, 1'b1);
    tick();
    prg_req = 1'b0;
    wait_done(1'b0, c);
    chk_cnt++;
    if (prg_rdata !== 8'h3C) $display("FAIL dis_prep_data got %h want 3c", prg_rdata);
    else pass_cnt++;
    tick(); tick();
    m0 = n_mem;
    prg_issue(22'h000041, 1'b1, 8'h77, 1'b0);
    tick();
    prg_req = 1'b0;
    chk_cnt++;
    if ({mem_req, prg_done} !== 2'b00)
      $display("FAIL dis_wr_c1 got %b want 00", {mem_req, prg_done});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (prg_done !== 1'b1) $display("FAIL dis_wr_done got %b want 1", prg_done);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'h3C) $display("FAIL dis_wr_rdata got %h want 3c", prg_rdata);
    else pass_cnt++;
    tick();
    prg_issue(22'h000042, 1'b0, 8'h00, 1'b0);
    tick();
    prg_req = 1'b0;
    chk_cnt++;
    if (prg_done !== 1'b0) $display("FAIL dis_rd_c1 got %b want 0", prg_done);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (prg_done !== 1'b1) $display("FAIL dis_rd_done got %b want 1", prg_done);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'h3C) $display("FAIL dis_rd_data got %h want 3c", prg_rdata);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (n_mem - m0 !== 0) $display("FAIL dis_no_mem got %0d want 0", n_mem - m0);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    bit low;
    mute = 1'b1;
    n = 0;
    low = 1'b0;
    chr_issue(22'h2ABCDE, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 100 && !low; i++) begin
      tick();
      chr_req = 1'b0;
      if (mem_req) n++;
      else low = 1'b1;
    end
    chk_cnt++;
    if (n !== 64) $display("FAIL to_req_cycles got %0d want 64", n);
    else pass_cnt++;
    chk_cnt++;
    if (chr_done !== 1'b1) $display("FAIL to_done got %b want 1", chr_done);
    else pass_cnt++;
    chk_cnt++;
    if (chr_rdata !== 8'hFF) $display("FAIL to_rdata got %h want ff", chr_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (timeout_err !== 1'b1) $display("FAIL to_err got %b want 1", timeout_err);
    else pass_cnt++;
    mute = 1'b0;
    tick(); tick();
  endtask

  task automatic test_overflow();
    int c, m0, d0;
    do_reset();
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow);
    else pass_cnt++;
    mem_lat = 6; mem_data = 8'h11;
    m0 = n_mem; d0 = n_pdone;
    prg_issue(22'h000010, 1'b0, 8'h00, 1'b1);
    tick();
    prg_req = 1'b0;
    tick();
    prg_issue(22'h000020, 1'b0, 8'h00, 1'b1);
    tick();
    prg_req = 1'b0;
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow);
    else pass_cnt++;
    chk_cnt++;
    if (mem_addr !== 22'h000010) $display("FAIL ovf_addr got %h want 000010", mem_addr);
    else pass_cnt++;
    wait_done(1'b0, c);
    chk_cnt++;
    if (c !== 4) $display("FAIL ovf_lat got %0d want 4", c);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'h11) $display("FAIL ovf_data got %h want 11", prg_rdata);
    else pass_cnt++;
    tick(); tick(); tick(); tick();
    chk_cnt++;
    if ((n_mem - m0 !== 1) || (n_pdone - d0 !== 1))
      $display("FAIL ovf_counts got %0d/%0d want 1/1", n_mem - m0, n_pdone - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mem();
    int c, d0;
    mute = 1'b1;
    d0 = n_pdone;
    prg_issue(22'h000055, 1'b0, 8'h00, 1'b1);
    tick();
    prg_req = 1'b0;
    tick();
    chk_cnt++;
    if (mem_req !== 1'b1) $display("FAIL mid_in_mem got %b want 1", mem_req);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (mem_req !== 1'b0) $display("FAIL mid_async_drop got %b want 0", mem_req);
    else pass_cnt++;
    tick(); tick();
    reset_n = 1'b1;
    mute = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (n_pdone - d0 !== 0) $display("FAIL mid_no_done got %0d want 0", n_pdone - d0);
    else pass_cnt++;
    chk_cnt++;
    if ({overflow, timeout_err} !== 2'b00)
      $display("FAIL mid_flags got %b want 00", {overflow, timeout_err});
    else pass_cnt++;
    mem_lat = 2; mem_data = 8'h99;
    prg_issue(22'h000066, 1'b0, 8'h00, 1'b1);
    tick();
    prg_req = 1'b0;
    wait_done(1'b0, c);
    chk_cnt++;
    if (c !== 2) $display("FAIL mid_fresh_lat got %0d want 2", c);
    else pass_cnt++;
    chk_cnt++;
    if (prg_rdata !== 8'h99) $display("FAIL mid_fresh_data got %h want 99", prg_rdata);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_prg_read();
    test_both();
    test_disallowed();
    test_timeout();
    test_overflow();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
